tdc_pulse_gen: RTL and testbench
================================

// Module: tdc_pulse_gen
// PURPOSE
//  Digital-to-time stimulus source for the TDC: emits a start/stop edge pair whose rising edges are a programmed
//  number of delay_clk cycles apart, so the TDC delay line can be characterised on-chip.
//  32-bit delay code is byte-loaded through the same 2-bit-select / 8-bit lane scheme the TDC uses for readout.
//  Sits beside the TDC top; start_out drives the delay-line start, stop_out is the capture reference.
// PARAMETERS
//  N_DELAY     32  width of delay code / down-counter (multiple of 8, 8..32)
//  GAP_CYCLES  4   idle cycles between pulse pairs in a burst (>=1)
// PORTS
//  delay_clk  in   1        single system clock, all state on posedge
//  rst_n      in   1        reset: asynchronous, active-high (asserted = 1)
//  load_data  in   8        byte to write into delay code
//  load_sel   in   2        byte lane: 00=[7:0] 01=[15:8] 10=[23:16] 11=[31:24]
//  load_en    in   1        write strobe, sampled on posedge
//  trigger    in   1        rising edge requests a measurement sequence
//  burst_len  in   4        extra repetitions (total pairs = burst_len+1), sampled at accepted trigger
//  start_out  out  1        TDC start level
//  stop_out   out  1        one-cycle stop/capture pulse
//  busy       out  1        sequence in progress
//  done       out  1        one-cycle pulse after final pair
//  overrun    out  1        sticky: trigger edge arrived while busy
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset (async, immediate): delay_reg=0, FSM=IDLE, start_out=stop_out=busy=done=overrun=0, trig_q=0.
//  All outputs registered. Trigger edge = trigger & ~trig_q (trig_q = trigger delayed 1 cycle).
//  Load: in IDLE, load_en writes load_data into lane load_sel of delay_reg; lanes >= N_DELAY/8 ignored.
//   load_en in any other state ignored. load_en in IDLE also clears overrun.
//  D = delay_reg, with D=0 treated as D=1. Counter loaded from D at trigger; later loads never affect a run.
//  FSM: IDLE -> RUN -> STOP -> (GAP -> RUN ...) -> IDLE.
//   IDLE: busy=0. Trigger edge sampled at edge 0 -> RUN at edge 1: start_out=1, busy=1, cnt=D, reps=burst_len.
//   RUN: cnt decrements each cycle; when cnt reaches 1 -> STOP.
//   STOP: stop_out=1 for exactly one cycle at edge s+D (s = start rise edge); start_out still 1 in this cycle.
//    Next edge: start_out=0, stop_out=0; if reps==0 -> IDLE with done=1 for one cycle, busy=0; else GAP.
//   GAP: both low for GAP_CYCLES cycles, reps-=1, then RUN (start rises at s+D+GAP_CYCLES+1).
//  Timing per pair: start high edges s..s+D (D+1 cycles); stop rise - start rise = D cycles exactly.
//  Trigger edge while busy (incl. done cycle excluded; done cycle is IDLE): ignored, overrun<=1.
//  Trigger edge coincident with load_en in IDLE: load applied, sequence uses NEW value (load has priority
//   in same cycle: counter loads the updated delay_reg lane).
//  Counter is N_DELAY bits; max D = 2^N_DELAY-1, no wrap (stops at 1).
//  Reset mid-sequence: outputs drop immediately, no done pulse, delay_reg cleared.
// CONFIGURATION
//  TDCGEN_BURST_EN defined: burst_len honoured, GAP state present, total pairs = burst_len+1.
//  TDCGEN_BURST_EN undefined: burst_len ignored, GAP state omitted, always a single pair then done.
// TESTING
//  1 Reset held then released, no stimulus -> all outputs 0; trigger edge -> stop at s+1 (delay_reg=0 -> D=1).
//  2 Load 0x05,0x00,0x00,0x00 to lanes 0..3, trigger edge at edge 0 -> start rises edge 1, stop only edge 6,
//    start falls edge 7, done=1 edge 7 only, busy 1 on edges 1..6.
//  3 Load 0x00000100 (D=256), trigger -> stop exactly 256 cycles after start rise; write lane 0=0xFF mid-run
//    -> ignored, run unchanged, delay_reg still 0x00000100 afterwards.
//  4 D=5, second trigger edge at edge 3 -> ignored, overrun=1 stays set; load_en in IDLE -> overrun=0.
//  5 TDCGEN_BURST_EN, D=5, burst_len=2 -> start rises edges 1,11,21; stops 6,16,26; done edge 27 only.
//    Without macro, same stimulus -> one pair, done edge 7.
//  6 D=20, assert rst_n at edge 8 (async, between edges) -> start_out/busy 0 immediately, FSM IDLE, no done.

Source files
------------

// File: rtl/tdc_pulse_gen_if.sv
// Load/trigger bus and pulse outputs of the TDC pulse generator.
// The master drives loads and triggers; the slave is the generator itself.
interface tdc_pulse_gen_if;
    logic [7:0] load_data;
    logic [1:0] load_sel;
    logic       load_en;
    logic       trigger;
    logic [3:0] burst_len;
    logic       start_out;
    logic       stop_out;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output load_data, load_sel, load_en, trigger, burst_len,
        input  start_out, stop_out, busy, done, overrun
    );

    modport slave (
        input  load_data, load_sel, load_en, trigger, burst_len,
        output start_out, stop_out, busy, done, overrun
    );
endinterface

// File: rtl/tdc_pulse_gen.sv
// Start/stop edge-pair source for on-chip TDC characterisation; stop rises exactly D cycles after start.
// Optional TDCGEN_BURST_EN enables bursts of burst_len+1 pairs separated by GAP_CYCLES idle cycles.
module tdc_pulse_gen #(
    parameter int N_DELAY    = 32,
    parameter int GAP_CYCLES = 4
) (
    input logic            delay_clk,
    input logic            rst_n,
    tdc_pulse_gen_if.slave bus
);

`ifdef TDCGEN_BURST_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2, ST_GAP = 2'd3} state_t;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [3:0]    reps_r, reps_nxt_s;
    logic [GW-1:0] gap_r, gap_nxt_s;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2} state_t;
`endif

    state_t             state_r, state_nxt_s;
    logic [N_DELAY-1:0] delay_r, delay_nxt_s;
    logic [N_DELAY-1:0] cnt_r, cnt_nxt_s;
    logic               trig_q_r;
    logic               trig_edge_s;
    logic               start_r, start_nxt_s;
    logic               stop_r, stop_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               overrun_r, overrun_nxt_s;

    // A zero code would never reach the stop threshold, so it runs as one cycle.
    function automatic logic [N_DELAY-1:0] eff_delay(input logic [N_DELAY-1:0] d);
        if (d == {N_DELAY{1'b0}}) begin
            return N_DELAY'(1);
        end else begin
            return d;
        end
    endfunction

    assign trig_edge_s   = bus.trigger & ~trig_q_r;
    assign bus.start_out = start_r;
    assign bus.stop_out  = stop_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.overrun   = overrun_r;

    // Next-state and next-output logic for the pulse sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        delay_nxt_s   = delay_r;
        cnt_nxt_s     = cnt_r;
        start_nxt_s   = start_r;
        stop_nxt_s    = 1'b0;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        overrun_nxt_s = overrun_r;
`ifdef TDCGEN_BURST_EN
        reps_nxt_s    = reps_r;
        gap_nxt_s     = gap_r;
`endif
        if (trig_edge_s && (state_r != ST_IDLE)) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.load_en) begin
                    overrun_nxt_s = 1'b0;
                    // Lanes beyond the code width simply match no slice.
                    for (int i = 0; i < N_DELAY / 8; i++) begin
                        if (int'(bus.load_sel) == i) begin
                            delay_nxt_s[i*8 +: 8] = bus.load_data;
                        end else begin
                            delay_nxt_s[i*8 +: 8] = delay_r[i*8 +: 8];
                        end
                    end
                end else begin
                    delay_nxt_s = delay_r;
                end
                if (trig_edge_s) begin
                    state_nxt_s = ST_RUN;
                    start_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b1;
                    cnt_nxt_s   = eff_delay(delay_nxt_s);
`ifdef TDCGEN_BURST_EN
                    reps_nxt_s  = bus.burst_len;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == N_DELAY'(1)) begin
                    state_nxt_s = ST_STOP;
                    stop_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - N_DELAY'(1);
                end
            end
            ST_STOP: begin
                start_nxt_s = 1'b0;
`ifdef TDCGEN_BURST_EN
                if (reps_r == 4'd0) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_GAP;
                    gap_nxt_s   = GW'(GAP_CYCLES - 1);
                end
`else
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
`endif
            end
`ifdef TDCGEN_BURST_EN
            ST_GAP: begin
                if (gap_r == GW'(0)) begin
                    state_nxt_s = ST_RUN;
                    start_nxt_s = 1'b1;
                    cnt_nxt_s   = eff_delay(delay_r);
                    reps_nxt_s  = reps_r - 4'd1;
                end else begin
                    gap_nxt_s   = gap_r - GW'(1);
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
                start_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, delay code and registered outputs; reset drops everything at once.
    always_ff @(posedge delay_clk or posedge rst_n) begin
        if (rst_n) begin
            state_r   <= ST_IDLE;
            delay_r   <= {N_DELAY{1'b0}};
            cnt_r     <= {N_DELAY{1'b0}};
            trig_q_r  <= 1'b0;
            start_r   <= 1'b0;
            stop_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
`ifdef TDCGEN_BURST_EN
            reps_r    <= 4'd0;
            gap_r     <= GW'(0);
`endif
        end else begin
            state_r   <= state_nxt_s;
            delay_r   <= delay_nxt_s;
            cnt_r     <= cnt_nxt_s;
            trig_q_r  <= bus.trigger;
            start_r   <= start_nxt_s;
            stop_r    <= stop_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            overrun_r <= overrun_nxt_s;
`ifdef TDCGEN_BURST_EN
            reps_r    <= reps_nxt_s;
            gap_r     <= gap_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Scoreboard bench for tdc_pulse_gen: expected start/stop/fall/done events are queued at trigger
// time and matched against events seen on the outputs, plus per-cycle busy and status checks.
module tb_tdc_pulse_gen;
    localparam int GAP = 4;
`ifdef TDCGEN_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic delay_clk;
    logic rst_n;
    int   cyc;
    int   vec_cnt;
    int   err_cnt;
    logic prev_start;
    logic [31:0] dmodel;
    ev_t  q[$];

    tdc_pulse_gen_if bus ();

    tdc_pulse_gen #(.N_DELAY(32), .GAP_CYCLES(GAP)) dut (
        .delay_clk (delay_clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
    );

    initial begin
        delay_clk = 1'b0;
        forever #5 delay_clk = ~delay_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge delay_clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // kind: 1 start rise, 2 stop pulse, 3 done pulse, 4 start fall
    task automatic ev(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", kind, 0);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    initial begin
        prev_start = 1'b0;
        forever begin
            @(negedge delay_clk);
            if (rst_n) begin
                prev_start = 1'b0;
            end else begin
                if (bus.start_out && !prev_start) ev(1);
                if (bus.stop_out) ev(2);
                if (!bus.start_out && prev_start) ev(4);
                if (bus.done) ev(3);
                prev_start = bus.start_out;
            end
        end
    end

    task automatic load_byte(input int sel, input logic [7:0] data);
        @(posedge delay_clk); #2;
        bus.load_en   = 1'b1;
        bus.load_sel  = sel[1:0];
        bus.load_data = data;
        dmodel[sel*8 +: 8] = data;
        @(posedge delay_clk); #2;
        bus.load_en = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) load_byte(i, w[i*8 +: 8]);
    endtask

    // mode 0 plain, 1 mid-run lane write, 2 second trigger while busy
    task automatic run_seq(input int bl, input int mode, input bit co_en, input logic [7:0] co_byte);
        int s, d, pairs, sp, last_stop, done_c;
        @(posedge delay_clk); #2;
        if (co_en) begin
            bus.load_en   = 1'b1;
            bus.load_sel  = 2'd0;
            bus.load_data = co_byte;
            dmodel[7:0]   = co_byte;
        end
        bus.trigger   = 1'b1;
        bus.burst_len = bl[3:0];
        s     = cyc + 1;
        d     = (dmodel == 32'd0) ? 1 : int'(dmodel);
        pairs = BURST ? bl + 1 : 1;
        sp    = s;
        for (int p = 0; p < pairs; p++) begin
            sp = s + p * (d + GAP + 1);
            push(1, sp);
            push(2, sp + d);
            push(4, sp + d + 1);
        end
        last_stop = sp + d;
        done_c    = last_stop + 1;
        push(3, done_c);
        @(posedge delay_clk); #2;
        bus.trigger   = 1'b0;
        bus.load_en   = 1'b0;
        bus.burst_len = 4'd0;
        while (cyc < done_c + 2) begin
            @(negedge delay_clk);
            chk("busy", bus.busy, (cyc >= s && cyc <= last_stop));
            if (mode == 1 && cyc == s + 10) begin
                bus.load_en   = 1'b1;
                bus.load_sel  = 2'd0;
                bus.load_data = 8'hFF;
            end else if (mode == 1 && cyc == s + 11) begin
                bus.load_en = 1'b0;
            end
            if (mode == 2 && cyc == s + 1) bus.trigger = 1'b1;
            else if (mode == 2 && cyc == s + 2) bus.trigger = 1'b0;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic check_idle_outputs(input int exp_ovr);
        chk("start_out", bus.start_out, 0);
        chk("stop_out", bus.stop_out, 0);
        chk("busy_idle", bus.busy, 0);
        chk("done_idle", bus.done, 0);
        chk("overrun", bus.overrun, exp_ovr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        vec_cnt = 0;
        err_cnt = 0;
        dmodel  = 32'd0;
        rst_n   = 1'b1;
        bus.load_data = 8'd0;
        bus.load_sel  = 2'd0;
        bus.load_en   = 1'b0;
        bus.trigger   = 1'b0;
        bus.burst_len = 4'd0;

        // Reset held, then released with no stimulus
        repeat (3) @(negedge delay_clk);
        check_idle_outputs(0);
        @(posedge delay_clk); #2;
        rst_n = 1'b0;
        repeat (3) @(negedge delay_clk);
        check_idle_outputs(0);
        run_seq(0, 0, 1'b0, 8'd0);                 // delay_reg = 0 runs as D = 1

        // D = 5 byte-loaded, single pair
        load_word(32'h0000_0005);
        run_seq(0, 0, 1'b0, 8'd0);

        // D = 256 with an ignored lane write mid-run, then rerun to confirm code unchanged
        load_word(32'h0000_0100);
        run_seq(0, 1, 1'b0, 8'd0);
        run_seq(0, 0, 1'b0, 8'd0);

        // Second trigger while busy sets sticky overrun; a load in IDLE clears it
        load_word(32'h0000_0005);
        run_seq(0, 2, 1'b0, 8'd0);
        @(negedge delay_clk);
        chk("overrun_sticky", bus.overrun, 1);
        load_byte(0, 8'h05);
        @(negedge delay_clk);
        chk("overrun_cleared", bus.overrun, 0);

        // Burst of burst_len+1 pairs (single pair when bursts are compiled out)
        run_seq(2, 0, 1'b0, 8'd0);

        // Load coincident with trigger: the run uses the freshly written lane
        run_seq(0, 0, 1'b1, 8'h07);

        // Asynchronous reset in the middle of a D = 20 run
        load_word(32'h0000_0014);
        @(posedge delay_clk); #2;
        bus.trigger = 1'b1;
        s = cyc + 1;
        push(1, s);
        @(posedge delay_clk); #2;
        bus.trigger = 1'b0;
        while (cyc < s + 7) @(negedge delay_clk);
        #1 rst_n = 1'b1;
        #1;
        check_idle_outputs(0);
        repeat (2) @(posedge delay_clk);
        #2 rst_n = 1'b0;
        dmodel = 32'd0;
        chk("reset_queue", q.size(), 0);
        repeat (30) begin
            @(negedge delay_clk);
            chk("no_done_after_reset", bus.done, 0);
        end
        run_seq(0, 0, 1'b0, 8'd0);                 // delay_reg cleared by reset -> D = 1

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
